// File: rtl/hist_bin_writer_pkg.sv
// hist_bin_writer_pkg
//   Shared constants and types for the histogram producer and the CDF stage
//   that consumes its scratch-memory layout.
//   - NUM_BINS / BINS_PER_WORD / HIST_WORDS : histogram geometry
//   - HIST_BASE / CDF_BASE                  : scratch memory regions
//   - state_e                               : histogram writer FSM states
//   - word_first_bin()                      : first bin index packed in a word
package hist_bin_writer_pkg;

    localparam int NUM_BINS      = 256;
    localparam int BINS_PER_WORD = 4;
    localparam int HIST_WORDS    = NUM_BINS / BINS_PER_WORD;

    localparam logic [15:0] HIST_BASE = 16'd0;
    localparam logic [15:0] CDF_BASE  = 16'd64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Word k carries bins 4k..4k+3, with bin 4k in the most significant slot.
    function automatic logic [7:0] word_first_bin(input logic [5:0] k);
        return {k, 2'b00};
    endfunction

endpackage

// File: rtl/hist_bin_array.sv
// hist_bin_array
//   256 saturating bins with one increment port and one word-wide
//   read-and-clear port.
//   - clk, reset   : posedge clock, synchronous active-high reset (bins -> 0)
//   - inc_en/idx   : add one to bin[inc_idx] at the next edge (holds at max)
//   - clr_en       : clear the four bins of word_idx at the next edge
//   - word_idx     : selects the four bins presented on word_data
//   - word_data    : {bin[4k], bin[4k+1], bin[4k+2], bin[4k+3]} (combinational)
module hist_bin_array
    import hist_bin_writer_pkg::*;
#(
    parameter int BIN_W = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inc_en,
    input  logic [7:0]                     inc_idx,
    input  logic                           clr_en,
    input  logic [5:0]                     word_idx,
    output logic [BINS_PER_WORD*BIN_W-1:0] word_data
);

    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    logic [BIN_W-1:0] bin_vec [NUM_BINS];

    // Each bin owns its own register, so an increment is a read-modify-write
    // of that bin alone and repeated pixels of one value count every cycle.
    for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
        localparam logic [7:0] BIN_IDX  = 8'(i);
        localparam logic [5:0] WORD_IDX = 6'(i / BINS_PER_WORD);

        logic [BIN_W-1:0] bin_q;
        logic [BIN_W-1:0] bin_d;

        always_comb begin
            bin_d = bin_q;
            if (clr_en && (word_idx == WORD_IDX)) begin
                bin_d = '0;
            end else if (inc_en && (inc_idx == BIN_IDX) && (bin_q != BIN_MAX)) begin
                bin_d = bin_q + BIN_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                bin_q <= '0;
            end else begin
                bin_q <= bin_d;
            end
        end

        assign bin_vec[i] = bin_q;
    end

    logic [7:0] base_idx;

    always_comb begin
        base_idx  = word_first_bin(word_idx);
        word_data = {bin_vec[base_idx],
                     bin_vec[base_idx + 8'd1],
                     bin_vec[base_idx + 8'd2],
                     bin_vec[base_idx + 8'd3]};
    end

endmodule

// File: rtl/hist_bin_writer.sv
// hist_bin_writer
//   Counts 8-bit pixel intensities into 256 saturating bins over one frame,
//   then writes them to scratch memory as 64 words of four bins each at
//   BASE_ADDR..BASE_ADDR+63, clearing the bins as they go.
//   - clk, reset        : posedge clock, synchronous active-high reset
//   - frame_start_in    : start-of-frame pulse (accepted only when idle)
//   - pixel_valid_in    : qualifies pixel_in this cycle
//   - pixel_in          : intensity, used directly as the bin index
//   - frame_done_in     : end-of-frame pulse, starts the flush
//   - WE/WriteAddress/WriteBus : scratch memory write port
//   - hist_done         : one-cycle pulse after the last word is written
//   - busy              : high from frame acceptance through hist_done
//
// Handshake: pixel_valid_in is a plain valid with no ready. Every cycle it
// is high while accumulating, pixel_in is counted; the block never stalls
// the source. The scratch write port is likewise fire-and-forget: WE high
// means the word on WriteBus lands at WriteAddress that cycle.
module hist_bin_writer
    import hist_bin_writer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = HIST_BASE,
    parameter int          BIN_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start_in,
    input  logic                           pixel_valid_in,
    input  logic [7:0]                     pixel_in,
    input  logic                           frame_done_in,
    output logic                           WE,
    output logic [15:0]                    WriteAddress,
    output logic [BINS_PER_WORD*BIN_W-1:0] WriteBus,
    output logic                           hist_done,
    output logic                           busy
);

    localparam int WORD_W = BINS_PER_WORD * BIN_W;

    // Input stage
    logic       frame_start_q, frame_start_d;
    logic       pixel_valid_q, pixel_valid_d;
    logic [7:0] pixel_q,       pixel_d;
    logic       frame_done_q,  frame_done_d;

    // Control and output registers
    state_e            state_q,     state_d;
    logic [5:0]        word_cnt_q,  word_cnt_d;
    logic              we_q,        we_d;
    logic [15:0]       addr_q,      addr_d;
    logic [WORD_W-1:0] bus_q,       bus_d;
    logic              hist_done_q, hist_done_d;
    logic              busy_q,      busy_d;

    // Bin array control
    logic              inc_en;
    logic              clr_en;
    logic [WORD_W-1:0] word_data;

    hist_bin_array #(
        .BIN_W (BIN_W)
    ) u_bins (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (inc_en),
        .inc_idx   (pixel_q),
        .clr_en    (clr_en),
        .word_idx  (word_cnt_q),
        .word_data (word_data)
    );

    always_comb begin
        frame_start_d = frame_start_in;
        pixel_valid_d = pixel_valid_in;
        pixel_d       = pixel_in;
        frame_done_d  = frame_done_in;

        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        bus_d       = bus_q;
        hist_done_d = 1'b0;
        busy_d      = busy_q;
        inc_en      = 1'b0;
        clr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (frame_start_q) begin
                    state_d = ST_ACCUM;
                    busy_d  = 1'b1;
                end
            end
            ST_ACCUM: begin
                // A pixel arriving alongside frame_done is still counted:
                // the increment lands on the same edge that leaves ACCUM.
                inc_en = pixel_valid_q;
                if (frame_done_q) begin
                    state_d    = ST_FLUSH;
                    word_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                // Latch word k and clear its bins on the same edge.
                clr_en     = 1'b1;
                we_d       = 1'b1;
                addr_d     = BASE_ADDR + {10'd0, word_cnt_q};
                bus_d      = word_data;
                word_cnt_d = word_cnt_q + 6'd1;
                if (word_cnt_q == 6'(HIST_WORDS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hist_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start_q <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_q       <= '0;
            frame_done_q  <= 1'b0;
            state_q       <= ST_IDLE;
            word_cnt_q    <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            bus_q         <= '0;
            hist_done_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_q       <= pixel_d;
            frame_done_q  <= frame_done_d;
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            bus_q         <= bus_d;
            hist_done_q   <= hist_done_d;
            busy_q        <= busy_d;
        end
    end

    assign WE           = we_q;
    assign WriteAddress = addr_q;
    assign WriteBus     = bus_q;
    assign hist_done    = hist_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hist_bin_writer.sv
// tb_hist_bin_writer
//   Self-checking bench for hist_bin_writer. A reference histogram (plain
//   array of counters with saturation) predicts the 64 scratch words of each
//   flush; a monitor records every write and every hist_done pulse.
module tb_hist_bin_writer;

    localparam int NB      = 256;
    localparam int NW      = 64;
    localparam int TIMEOUT = 400;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_start_in;
    logic         pixel_valid_in;
    logic [7:0]   pixel_in;
    logic         frame_done_in;
    logic         WE;
    logic [15:0]  WriteAddress;
    logic [127:0] WriteBus;
    logic         hist_done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    hist_bin_writer dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start_in (frame_start_in),
        .pixel_valid_in (pixel_valid_in),
        .pixel_in       (pixel_in),
        .frame_done_in  (frame_done_in),
        .WE             (WE),
        .WriteAddress   (WriteAddress),
        .WriteBus       (WriteBus),
        .hist_done      (hist_done),
        .busy           (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor ----------------
    logic [15:0]  wr_addr_q [$];
    logic [127:0] wr_data_q [$];
    int           wr_cyc_q  [$];
    int           done_cyc_q[$];

    always @(negedge clk) begin
        if (WE === 1'b1) begin
            wr_addr_q.push_back(WriteAddress);
            wr_data_q.push_back(WriteBus);
            wr_cyc_q.push_back(cyc);
        end
        if (hist_done === 1'b1) done_cyc_q.push_back(cyc);
    end

    task automatic clear_capture();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    // ---------------- reference model ----------------
    logic [31:0]  model_bins [NB];
    logic [127:0] exp_q [$];

    task automatic model_clear();
        for (int i = 0; i < NB; i++) model_bins[i] = 32'd0;
    endtask

    task automatic model_pixel(input logic [7:0] p);
        if (model_bins[p] != 32'hFFFF_FFFF) model_bins[p] = model_bins[p] + 32'd1;
    endtask

    // Snapshot the histogram as the 64 words a flush should produce; the
    // flush empties the histogram afterwards.
    task automatic model_build_expected();
        exp_q.delete();
        for (int k = 0; k < NW; k++)
            exp_q.push_back({model_bins[4*k], model_bins[4*k+1],
                             model_bins[4*k+2], model_bins[4*k+3]});
        model_clear();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        frame_start_in = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_in       = 8'd0;
        frame_done_in  = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        idle_inputs();
        frame_start_in = 1'b1;
        @(negedge clk);
        frame_start_in = 1'b0;
    endtask

    task automatic gen_random(output logic [7:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sends pixels (optionally with idle gaps and ignored frame_start noise),
    // then frame_done. t_done is the edge at which frame_done is sampled.
    task automatic send_pixels(input logic [7:0] pix[$], input int gap_max,
                               input bit done_with_last, input bit start_noise,
                               output int t_done);
        int gaps;
        t_done = -1;
        for (int i = 0; i < pix.size(); i++) begin
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (gaps) begin
                idle_inputs();
                frame_start_in = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
            idle_inputs();
            pixel_valid_in = 1'b1;
            pixel_in       = pix[i];
            model_pixel(pix[i]);
            if (start_noise) frame_start_in = 1'($urandom_range(0, 1));
            if (done_with_last && (i == pix.size() - 1)) begin
                frame_done_in = 1'b1;
                t_done        = cyc + 1;
            end
            @(negedge clk);
        end
        idle_inputs();
        if (!done_with_last || (pix.size() == 0)) begin
            frame_done_in  = 1'b1;
            frame_start_in = start_noise;
            t_done         = cyc + 1;
            @(negedge clk);
            idle_inputs();
        end
    endtask

    // Waits (bounded) for hist_done; returns at the negedge where it is seen.
    // With junk set, drives random pixels/frame_start/frame_done during the
    // early part of the flush.
    task automatic wait_done(input bit junk, output bit ok, output int done_cyc);
        ok       = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (hist_done === 1'b1) begin
                ok       = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (junk && (WE === 1'b1) && (WriteAddress < 16'd60)) begin
                frame_start_in = 1'($urandom_range(0, 1));
                pixel_valid_in = 1'b1;
                pixel_in       = 8'($urandom_range(0, 255));
                frame_done_in  = 1'($urandom_range(0, 1));
            end else begin
                idle_inputs();
            end
        end
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", WE); end
        checks++;
        if (WriteAddress !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", WriteAddress); end
        checks++;
        if (WriteBus !== 128'd0) begin errors++; $display("FAIL reset_bus: got %h required 0", WriteBus); end
        checks++;
        if (hist_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", hist_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        reset = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_uniform();
        logic [7:0] pix[$];
        int t_done, done_cyc;
        bit ok;
        clear_capture();
        for (int i = 0; i < NB; i++) pix.push_back(8'(i));
        start_frame();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL uniform_busy_accum: got %b required 1", busy); end
        send_pixels(pix, 0, 1'b0, 1'b0, t_done);
        model_build_expected();
        wait_done(1'b0, ok, done_cyc);
        checks++;
        if (!ok) begin errors++; $display("FAIL uniform_timeout: got no hist_done required pulse within %0d", TIMEOUT); end
        checks++;
        if (done_cyc !== t_done + 66) begin errors++; $display("FAIL uniform_done_edge: got %0d required %0d", done_cyc, t_done + 66); end
        @(negedge clk);
        checks++;
        if (hist_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL uniform_after_done: got hist_done=%b busy=%b required 0/0", hist_done, busy);
        end
        checks++;
        if (wr_addr_q.size() != NW) begin errors++; $display("FAIL uniform_count: got %0d required %0d", wr_addr_q.size(), NW); end
        if (wr_cyc_q.size() == NW) begin
            checks++;
            if (wr_cyc_q[0] != t_done + 2 || wr_cyc_q[NW-1] != t_done + 65) begin
                errors++; $display("FAIL uniform_write_window: got %0d..%0d required %0d..%0d",
                                   wr_cyc_q[0], wr_cyc_q[NW-1], t_done + 2, t_done + 65);
            end
        end
        for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[k] !== 16'(k) || wr_data_q[k] !== exp_q[k] || wr_data_q[k] !== {4{32'd1}}) begin
                errors++; $display("FAIL uniform_word%0d: got addr %h data %h required addr %h data %h",
                                   k, wr_addr_q[k], wr_data_q[k], 16'(k), exp_q[k]);
            end
        end
        checks++;
        if (done_cyc_q.size() != 1) begin errors++; $display("FAIL uniform_done_pulses: got %0d required 1", done_cyc_q.size()); end
    endtask

    task automatic test_single_bin();
        logic [7:0] pix[$];
        int t_done, done_cyc;
        bit ok;
        clear_capture();
        for (int i = 0; i < 1000; i++) pix.push_back(8'd7);
        start_frame();
        send_pixels(pix, 0, 1'b1, 1'b0, t_done);
        model_build_expected();
        wait_done(1'b0, ok, done_cyc);
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got no hist_done required pulse"); end
        checks++;
        if (wr_addr_q.size() != NW) begin errors++; $display("FAIL single_count: got %0d required %0d", wr_addr_q.size(), NW); end
        else begin
            checks++;
            if (wr_data_q[1] !== {96'd0, 32'd1000}) begin
                errors++; $display("FAIL single_word1: got %h required %h", wr_data_q[1], {96'd0, 32'd1000});
            end
        end
        for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[k] !== 16'(k) || wr_data_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL single_word%0d: got addr %h data %h required addr %h data %h",
                                   k, wr_addr_q[k], wr_data_q[k], 16'(k), exp_q[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] pix[$];
        int t_done, done_cyc;
        bit ok;
        clear_capture();
        start_frame();
        @(negedge clk);
        force dut.u_bins.g_bin[255].bin_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.u_bins.g_bin[255].bin_q;
        model_bins[255] = 32'hFFFF_FFFE;
        pix = '{8'd255, 8'd254, 8'd255, 8'd255, 8'd3};
        send_pixels(pix, 2, 1'b0, 1'b0, t_done);
        model_build_expected();
        wait_done(1'b0, ok, done_cyc);
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_timeout: got no hist_done required pulse"); end
        checks++;
        if (wr_addr_q.size() != NW) begin errors++; $display("FAIL sat_count: got %0d required %0d", wr_addr_q.size(), NW); end
        else begin
            checks++;
            if (wr_data_q[63][31:0] !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL sat_bin255: got %h required ffffffff", wr_data_q[63][31:0]);
            end
        end
        for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_data_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL sat_word%0d: got %h required %h", k, wr_data_q[k], exp_q[k]);
            end
        end
    endtask

    // Random frames with idle gaps, ignored frame_start during ACCUM, and
    // frame_start coinciding with frame_done (frame_done must win).
    task automatic test_random_frames();
        logic [7:0] pix[$];
        int t_done, done_cyc, mism;
        bit ok;
        for (int f = 0; f < 3; f++) begin
            clear_capture();
            gen_random(pix, $urandom_range(100, 500));
            start_frame();
            send_pixels(pix, 3, 1'($urandom_range(0, 1)), 1'b1, t_done);
            model_build_expected();
            wait_done(1'b0, ok, done_cyc);
            @(negedge clk);
            checks++;
            if (!ok || done_cyc != t_done + 66) begin
                errors++; $display("FAIL rand%0d_done: got ok=%0d edge %0d required edge %0d", f, ok, done_cyc, t_done + 66);
            end
            mism = 0;
            for (int k = 0; k < NW && k < wr_addr_q.size(); k++)
                if (wr_addr_q[k] !== 16'(k) || wr_data_q[k] !== exp_q[k]) mism++;
            checks++;
            if (wr_addr_q.size() != NW || mism != 0) begin
                errors++; $display("FAIL rand%0d_words: got %0d writes %0d bad words required %0d writes 0 bad",
                                   f, wr_addr_q.size(), mism, NW);
            end
            // Settle in IDLE; a stray start would raise busy.
            repeat (3) @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_idle_busy: got %b required 0", f, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pix[$];
        int t_done, done_cyc;
        bit ok;
        clear_capture();
        gen_random(pix, 300);
        start_frame();
        send_pixels(pix, 1, 1'b0, 1'b0, t_done);
        model_build_expected();
        wait_done(1'b1, ok, done_cyc);
        // Next frame starts with zero gap after hist_done.
        frame_start_in = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no hist_done required pulse"); end
        checks++;
        if (wr_addr_q.size() != NW) begin errors++; $display("FAIL b2b_first_count: got %0d required %0d", wr_addr_q.size(), NW); end
        for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[k] !== 16'(k) || wr_data_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL b2b_first_word%0d: got addr %h data %h required addr %h data %h",
                                   k, wr_addr_q[k], wr_data_q[k], 16'(k), exp_q[k]);
            end
        end
        @(negedge clk);
        frame_start_in = 1'b0;
        clear_capture();
        pix = '{8'd4};
        send_pixels(pix, 0, 1'b0, 1'b0, t_done);
        model_build_expected();
        wait_done(1'b0, ok, done_cyc);
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got no hist_done required pulse"); end
        checks++;
        if (wr_addr_q.size() != NW) begin errors++; $display("FAIL b2b_second_count: got %0d required %0d", wr_addr_q.size(), NW); end
        else begin
            checks++;
            if (wr_data_q[1] !== {32'd1, 96'd0}) begin
                errors++; $display("FAIL b2b_second_word1: got %h required %h", wr_data_q[1], {32'd1, 96'd0});
            end
        end
        for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_data_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL b2b_second_word%0d: got %h required %h", k, wr_data_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [7:0] pix[$];
        int t_done, done_cyc;
        bit ok;
        clear_capture();
        gen_random(pix, 200);
        start_frame();
        send_pixels(pix, 0, 1'b0, 1'b0, t_done);
        while (cyc < t_done + 29) @(negedge clk);
        checks++;
        if (WE !== 1'b1) begin errors++; $display("FAIL rst_flush_active: got WE=%b required 1", WE); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (WE !== 1'b0 || busy !== 1'b0 || hist_done !== 1'b0) begin
            errors++; $display("FAIL rst_flush_abort: got WE=%b busy=%b hist_done=%b required 0/0/0", WE, busy, hist_done);
        end
        checks++;
        if (WriteAddress !== 16'd0 || WriteBus !== 128'd0) begin
            errors++; $display("FAIL rst_flush_outputs: got addr %h bus %h required 0/0", WriteAddress, WriteBus);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        clear_capture();
        repeat (80) @(negedge clk);
        checks++;
        if (done_cyc_q.size() != 0 || wr_addr_q.size() != 0) begin
            errors++; $display("FAIL rst_flush_quiet: got %0d done pulses %0d writes required 0/0", done_cyc_q.size(), wr_addr_q.size());
        end
        // Empty frame: every bin must read back zero.
        pix.delete();
        start_frame();
        send_pixels(pix, 0, 1'b0, 1'b0, t_done);
        model_build_expected();
        wait_done(1'b0, ok, done_cyc);
        @(negedge clk);
        checks++;
        if (!ok || wr_addr_q.size() != NW) begin
            errors++; $display("FAIL rst_empty_frame: got ok=%0d %0d writes required 1/%0d", ok, wr_addr_q.size(), NW);
        end
        for (int k = 0; k < NW && k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_data_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL rst_empty_word%0d: got %h required %h", k, wr_data_q[k], exp_q[k]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_uniform();
        test_single_bin();
        test_saturation();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_flush();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
